// File: rtl/pipe_pkg.sv
// Shared types and constants for the hazard scoreboard: the shadow-entry
// layout plus helpers used by the stage registers and the top.
package pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'h00;
    localparam int         CNT_W    = 16;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } sb_entry_t;

    // A write is only visible to forwarding if it really lands in a real register.
    function automatic logic writes_reg(input sb_entry_t e);
        return e.vld & e.regwrite & (e.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the pipeline (master) and the hazard scoreboard (slave).
// Optional memory-wait signals exist only when HAZ_MEM_WAIT_EN is defined.
interface hazard_scoreboard_if;

    logic        i_d_vld;
    logic [4:0]  i_d_rs1_addr;
    logic [4:0]  i_d_rs2_addr;
    logic        i_d_rs1_used;
    logic        i_d_rs2_used;
    logic [4:0]  i_d_rd_addr;
    logic        i_d_regwrite;
    logic        i_d_is_load;
    logic        i_branch_taken_e;
    logic        o_stall_f;
    logic        o_stall_d;
    logic        o_flush_d;
    logic        o_flush_e;
    logic        o_regwrite_m;
    logic [4:0]  o_rd_addr_m;
    logic        o_regwrite_w;
    logic [4:0]  o_rd_addr_w;
    logic [15:0] o_stall_cnt;
`ifdef HAZ_MEM_WAIT_EN
    logic        i_mem_ready;
    logic        o_freeze;
`endif

    modport master (
        output i_d_vld, i_d_rs1_addr, i_d_rs2_addr, i_d_rs1_used, i_d_rs2_used,
               i_d_rd_addr, i_d_regwrite, i_d_is_load, i_branch_taken_e,
`ifdef HAZ_MEM_WAIT_EN
        output i_mem_ready,
        input  o_freeze,
`endif
        input  o_stall_f, o_stall_d, o_flush_d, o_flush_e,
               o_regwrite_m, o_rd_addr_m, o_regwrite_w, o_rd_addr_w, o_stall_cnt
    );

    modport slave (
        input  i_d_vld, i_d_rs1_addr, i_d_rs2_addr, i_d_rs1_used, i_d_rs2_used,
               i_d_rd_addr, i_d_regwrite, i_d_is_load, i_branch_taken_e,
`ifdef HAZ_MEM_WAIT_EN
        input  i_mem_ready,
        output o_freeze,
`endif
        output o_stall_f, o_stall_d, o_flush_d, o_flush_e,
               o_regwrite_m, o_rd_addr_m, o_regwrite_w, o_rd_addr_w, o_stall_cnt
    );

endinterface

// File: rtl/sb_stage_reg.sv
// One shadow-pipeline entry. Only the valid bit is reset; the payload is
// meaningless while vld=0 and is left unreset.
module sb_stage_reg
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      hold,
    input  logic      bubble,
    input  sb_entry_t d,
    output sb_entry_t q
);

    logic       vld_q;
    logic [4:0] rd_q;
    logic       regwrite_q;
    logic       is_load_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (!hold) begin
            vld_q <= d.vld & ~bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (!hold) begin
            rd_q       <= d.rd;
            regwrite_q <= d.regwrite;
            is_load_q  <= d.is_load;
        end
    end

    assign q = '{vld: vld_q, rd: rd_q, regwrite: regwrite_q, is_load: is_load_q};

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / branch hazard scoreboard with an E/M/W shadow pipeline.
// Define HAZ_MEM_WAIT_EN to add the i_mem_ready / o_freeze memory-wait hold.
module hazard_scoreboard
    import pipe_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    hazard_scoreboard_if.slave sb
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    sb_entry_t        ent_d;
    sb_entry_t        ent_p0;
    sb_entry_t        ent_p1;
    sb_entry_t        ent_p2;
    logic             freeze;
    logic             branch;
    logic             e_load_live;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;
    logic             flush_e;
    logic [CNT_W-1:0] stall_cnt_q;

`ifdef HAZ_MEM_WAIT_EN
    assign freeze    = ~sb.i_mem_ready;
    assign sb.o_freeze = freeze & i_rst_n;
`else
    assign freeze = 1'b0;
`endif

    assign branch = sb.i_branch_taken_e;

    // Only a valid load writing a real register can starve the D stage.
    assign e_load_live = ent_p0.vld & ent_p0.is_load & (ent_p0.rd != REG_ZERO);
    assign rs1_hit     = sb.i_d_rs1_used & (sb.i_d_rs1_addr == ent_p0.rd);
    assign rs2_hit     = sb.i_d_rs2_used & (sb.i_d_rs2_addr == ent_p0.rd);
    assign load_use    = sb.i_d_vld & e_load_live & (rs1_hit | rs2_hit);

    assign sb.o_stall_f = i_rst_n & load_use & ~branch;
    assign sb.o_stall_d = i_rst_n & load_use & ~branch;
    assign sb.o_flush_d = i_rst_n & branch & ~freeze;
    assign flush_e      = i_rst_n & (branch | load_use) & ~freeze;
    assign sb.o_flush_e = flush_e;

    assign ent_d = '{vld:      sb.i_d_vld,
                     rd:       sb.i_d_rd_addr,
                     regwrite: sb.i_d_regwrite,
                     is_load:  sb.i_d_is_load};

    // ---- D -> E ----
    sb_stage_reg u_stage_e (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (freeze),
        .bubble (flush_e),
        .d      (ent_d),
        .q      (ent_p0)
    );

    // ---- E -> M ----
    sb_stage_reg u_stage_m (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (freeze),
        .bubble (1'b0),
        .d      (ent_p0),
        .q      (ent_p1)
    );

    // ---- M -> W ----
    sb_stage_reg u_stage_w (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (freeze),
        .bubble (1'b0),
        .d      (ent_p1),
        .q      (ent_p2)
    );

    assign sb.o_regwrite_m = writes_reg(ent_p1);
    assign sb.o_rd_addr_m  = ent_p1.rd;
    assign sb.o_regwrite_w = writes_reg(ent_p2);
    assign sb.o_rd_addr_w  = ent_p2.rd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (load_use && !branch && !freeze) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign sb.o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, x0, branch priority,
// shadow pipeline timing, counter saturation and reset mid-stall.
module tb_hazard_scoreboard;

    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_errors;

    hazard_scoreboard_if sb_if ();

    hazard_scoreboard dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .sb      (sb_if)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic vld, input logic [4:0] rs1, input logic rs1u,
                         input logic [4:0] rs2, input logic rs2u,
                         input logic [4:0] rd, input logic rw, input logic ld);
        sb_if.i_d_vld      = vld;
        sb_if.i_d_rs1_addr = rs1;
        sb_if.i_d_rs1_used = rs1u;
        sb_if.i_d_rs2_addr = rs2;
        sb_if.i_d_rs2_used = rs2u;
        sb_if.i_d_rd_addr  = rd;
        sb_if.i_d_regwrite = rw;
        sb_if.i_d_is_load  = ld;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // One full load-use stall: load enters E, dependent op stalls one cycle.
    task automatic do_stall(input logic [4:0] r);
        set_d(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, r, 1'b1, 1'b1);
        next_cycle();
        set_d(1'b1, r, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        next_cycle();
        set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rst_n  = 1'b0;
        sb_if.i_branch_taken_e = 1'b1;
`ifdef HAZ_MEM_WAIT_EN
        sb_if.i_mem_ready = 1'b1;
`endif
        set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("rst_flush_d", sb_if.o_flush_d, 0);
        chk("rst_flush_e", sb_if.o_flush_e, 0);
        chk("rst_cnt", sb_if.o_stall_cnt, 0);
        chk("rst_regwrite_m", sb_if.o_regwrite_m, 0);
        sb_if.i_branch_taken_e = 1'b0;
        next_cycle();
        next_cycle();
        i_rst_n = 1'b1;
        next_cycle();

        // Load-use on rs1
        set_d(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        #1 chk("lu_pre_stall_f", sb_if.o_stall_f, 0);
        next_cycle();
        set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        chk("lu_stall_f", sb_if.o_stall_f, 1);
        chk("lu_stall_d", sb_if.o_stall_d, 1);
        chk("lu_flush_e", sb_if.o_flush_e, 1);
        chk("lu_flush_d", sb_if.o_flush_d, 0);
        next_cycle();
        #1;
        chk("lu_after_stall_d", sb_if.o_stall_d, 0);
        chk("lu_after_flush_e", sb_if.o_flush_e, 0);
        chk("lu_cnt", sb_if.o_stall_cnt, 1);
        chk("lu_regwrite_m", sb_if.o_regwrite_m, 1);
        chk("lu_rd_m", sb_if.o_rd_addr_m, 5);
        next_cycle();
        chk("lu_regwrite_w", sb_if.o_regwrite_w, 1);
        chk("lu_rd_w", sb_if.o_rd_addr_w, 5);
        chk("lu_bubble_m", sb_if.o_regwrite_m, 0);
        // E holds the non-load add x6: no hazard
        set_d(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        #1 chk("alu_no_stall", sb_if.o_stall_d, 0);
        next_cycle();

        // Load-use on rs2, with used/valid qualifiers
        set_d(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        next_cycle();
        set_d(1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 5'd13, 1'b1, 1'b0);
        #1 chk("rs2_unused", sb_if.o_stall_d, 0);
        sb_if.i_d_rs2_used = 1'b1;
        #1 chk("rs2_used", sb_if.o_stall_d, 1);
        sb_if.i_d_vld = 1'b0;
        #1 chk("d_invalid", sb_if.o_stall_d, 0);
        sb_if.i_d_vld = 1'b1;
        next_cycle();
        #1 chk("rs2_cnt", sb_if.o_stall_cnt, 2);

        // x0 destination
        set_d(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        next_cycle();
        set_d(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
        #1 chk("x0_no_stall", sb_if.o_stall_d, 0);
        next_cycle();
        chk("x0_regwrite_m", sb_if.o_regwrite_m, 0);

        // Branch together with load-use
        set_d(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        next_cycle();
        set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        sb_if.i_branch_taken_e = 1'b1;
        #1;
        chk("br_flush_d", sb_if.o_flush_d, 1);
        chk("br_flush_e", sb_if.o_flush_e, 1);
        chk("br_stall_d", sb_if.o_stall_d, 0);
        chk("br_stall_f", sb_if.o_stall_f, 0);
        next_cycle();
        sb_if.i_branch_taken_e = 1'b0;
        set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 chk("br_cnt", sb_if.o_stall_cnt, 2);
        next_cycle();
        chk("br_bubble_m", sb_if.o_regwrite_m, 0);

        // Shadow pipeline timing for add x7
        set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        next_cycle();
        set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        next_cycle();
        chk("shadow_regwrite_m", sb_if.o_regwrite_m, 1);
        chk("shadow_rd_m", sb_if.o_rd_addr_m, 7);
        next_cycle();
        chk("shadow_regwrite_w", sb_if.o_regwrite_w, 1);
        chk("shadow_rd_w", sb_if.o_rd_addr_w, 7);
        chk("shadow_m_empty", sb_if.o_regwrite_m, 0);

        // Counter saturation
        force dut.stall_cnt_q = 16'hFFFE;
        #1 release dut.stall_cnt_q;
        do_stall(5'd8);
        #1 chk("sat_first", sb_if.o_stall_cnt, 16'hFFFF);
        do_stall(5'd8);
        #1 chk("sat_held", sb_if.o_stall_cnt, 16'hFFFF);
        next_cycle();

        // Reset asserted during a load-use stall
        set_d(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        next_cycle();
        set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1 chk("rmid_stall_d", sb_if.o_stall_d, 1);
        i_rst_n = 1'b0;
        sb_if.i_branch_taken_e = 1'b1;
        #1;
        chk("rmid_stall_f", sb_if.o_stall_f, 0);
        chk("rmid_stall_d0", sb_if.o_stall_d, 0);
        chk("rmid_flush_e", sb_if.o_flush_e, 0);
        chk("rmid_flush_d", sb_if.o_flush_d, 0);
        chk("rmid_regwrite_w", sb_if.o_regwrite_w, 0);
        chk("rmid_cnt", sb_if.o_stall_cnt, 0);
        sb_if.i_branch_taken_e = 1'b0;
        next_cycle();
        i_rst_n = 1'b1;
        #1;
        chk("rrel_stall_d", sb_if.o_stall_d, 0);
        chk("rrel_regwrite_m", sb_if.o_regwrite_m, 0);
        chk("rrel_regwrite_w", sb_if.o_regwrite_w, 0);
        chk("rrel_cnt", sb_if.o_stall_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
